// File: rtl/tick_clock_counter.sv
// BCD hh:mm:ss time-of-day counter advanced by rising edges of a divided timer tick.
// Optional alarm comparator is enabled by defining ALARM_CMP_EN.
module tick_clock_counter #(
  parameter int HOUR_MOD    = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_in,
  input  logic       run,
  input  logic       inc_min,
  input  logic       inc_hour,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hour_bcd,
  output logic       sec_carry,
  output logic       day_wrap
`ifdef ALARM_CMP_EN
  ,
  input  logic [7:0] alarm_hour_bcd,
  input  logic [7:0] alarm_min_bcd,
  input  logic       alarm_arm,
  output logic       alarm
`endif
);

  localparam logic [7:0] HOUR_MAX_BCD = 8'(((HOUR_MOD - 1) / 10) * 16 + (HOUR_MOD - 1) % 10);

  function automatic logic [7:0] bcd_inc60(input logic [7:0] v);
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd5) return 8'h00;
      return {v[7:4] + 4'd1, 4'd0};
    end
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_inc_hour(input logic [7:0] v);
    if (v == HOUR_MAX_BCD) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  logic [SYNC_STAGES-1:0] tick_sync_p;
  logic                   tick_dly;
  logic                   inc_min_d;
  logic                   inc_hour_d;
  logic                   tick_evt;
  logic                   min_evt;
  logic                   hour_evt;

  // Stage: tick synchroniser, edge-detect delays for tick and set inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_sync_p <= '0;
      tick_dly    <= 1'b0;
      inc_min_d   <= 1'b0;
      inc_hour_d  <= 1'b0;
    end else begin
      tick_sync_p <= {tick_sync_p[SYNC_STAGES-2:0], tick_in};
      tick_dly    <= tick_sync_p[SYNC_STAGES-1];
      inc_min_d   <= inc_min;
      inc_hour_d  <= inc_hour;
    end
  end

  assign tick_evt = tick_sync_p[SYNC_STAGES-1] & ~tick_dly;
  assign min_evt  = inc_min & ~inc_min_d;
  assign hour_evt = inc_hour & ~inc_hour_d;

  logic [7:0] sec_n, min_n, hour_n;
  logic       carry_n, wrap_n, min_upd;

  // Set events take precedence; a tick arriving alongside one is dropped.
  always_comb begin
    sec_n   = sec_bcd;
    min_n   = min_bcd;
    hour_n  = hour_bcd;
    carry_n = 1'b0;
    wrap_n  = 1'b0;
    min_upd = 1'b0;
    if (min_evt || hour_evt) begin
      if (min_evt) begin
        min_n   = bcd_inc60(min_bcd);
        sec_n   = 8'h00;
        min_upd = 1'b1;
      end
      if (hour_evt) hour_n = bcd_inc_hour(hour_bcd);
    end else if (tick_evt && run) begin
      sec_n = bcd_inc60(sec_bcd);
      if (sec_bcd == 8'h59) begin
        carry_n = 1'b1;
        min_n   = bcd_inc60(min_bcd);
        min_upd = 1'b1;
        if (min_bcd == 8'h59) begin
          hour_n = bcd_inc_hour(hour_bcd);
          wrap_n = (hour_bcd == HOUR_MAX_BCD);
        end
      end
    end
  end

  // Stage: time-of-day registers and carry pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_bcd   <= 8'h00;
      min_bcd   <= 8'h00;
      hour_bcd  <= 8'h00;
      sec_carry <= 1'b0;
      day_wrap  <= 1'b0;
    end else begin
      sec_bcd   <= sec_n;
      min_bcd   <= min_n;
      hour_bcd  <= hour_n;
      sec_carry <= carry_n;
      day_wrap  <= wrap_n;
    end
  end

`ifdef ALARM_CMP_EN
  logic alarm_hit;
  assign alarm_hit = (hour_bcd == alarm_hour_bcd) && (min_bcd == alarm_min_bcd) &&
                     (sec_bcd == 8'h00);

  // Stage: alarm latch; a minute change or disarm clears it before any new match
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alarm <= 1'b0;
    else if (!alarm_arm || min_upd) alarm <= 1'b0;
    else if (alarm_hit) alarm <= 1'b1;
  end
`else
  logic unused_min_upd;
  assign unused_min_upd = min_upd;
`endif

endmodule

// File: tb/tb_tick_clock_counter.sv
// Directed bench for tick_clock_counter: a 24-hour and a 12-hour instance share stimulus.
module tb_tick_clock_counter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_in = 1'b0;
  logic       run = 1'b1;
  logic       inc_min = 1'b0;
  logic       inc_hour = 1'b0;
  logic [7:0] sec24, min24, hour24, sec12, min12, hour12;
  logic       carry24, wrap24, carry12, wrap12;
`ifdef ALARM_CMP_EN
  logic [7:0] al_hour = 8'h00;
  logic [7:0] al_min = 8'h00;
  logic       al_arm = 1'b0;
  logic       alarm24, alarm12;
`endif

  int total = 0;
  int passes = 0;
  int fails = 0;
  int carry24_cnt = 0, wrap24_cnt = 0, both24_cnt = 0;
  int carry12_cnt = 0, wrap12_cnt = 0, both12_cnt = 0;
  int c0;

  always #10 clk = ~clk;

  tick_clock_counter #(.HOUR_MOD(24), .SYNC_STAGES(2)) dut24 (
    .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .run(run),
    .inc_min(inc_min), .inc_hour(inc_hour),
    .sec_bcd(sec24), .min_bcd(min24), .hour_bcd(hour24),
    .sec_carry(carry24), .day_wrap(wrap24)
`ifdef ALARM_CMP_EN
    , .alarm_hour_bcd(al_hour), .alarm_min_bcd(al_min), .alarm_arm(al_arm), .alarm(alarm24)
`endif
  );

  tick_clock_counter #(.HOUR_MOD(12), .SYNC_STAGES(2)) dut12 (
    .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .run(run),
    .inc_min(inc_min), .inc_hour(inc_hour),
    .sec_bcd(sec12), .min_bcd(min12), .hour_bcd(hour12),
    .sec_carry(carry12), .day_wrap(wrap12)
`ifdef ALARM_CMP_EN
    , .alarm_hour_bcd(al_hour), .alarm_min_bcd(al_min), .alarm_arm(al_arm), .alarm(alarm12)
`endif
  );

  // Pulse counters: one count per clock cycle a pulse is high
  always @(negedge clk) begin
    if (carry24) carry24_cnt++;
    if (wrap24) wrap24_cnt++;
    if (carry24 && wrap24) both24_cnt++;
    if (carry12) carry12_cnt++;
    if (wrap12) wrap12_cnt++;
    if (carry12 && wrap12) both12_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) tick_in = 1'b1;
      repeat (2) @(negedge clk);
      tick_in = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic press_min(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) inc_min = 1'b1;
      @(negedge clk) inc_min = 1'b0;
    end
  endtask

  task automatic press_hour(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) inc_hour = 1'b1;
      @(negedge clk) inc_hour = 1'b0;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_sec", sec24, 8'h00);
    check("reset_min", min24, 8'h00);
    check("reset_hour", hour24, 8'h00);
    check("reset_carry", carry24, 1'b0);
    check("reset_wrap", wrap24, 1'b0);
    rst_n = 1'b1;

    tick(5);
    check("five_sec", sec24, 8'h05);
    check("five_min", min24, 8'h00);
    check("five_hour", hour24, 8'h00);
    check("five_no_carry", carry24_cnt, 0);

    tick(54);
    check("at59_sec", sec24, 8'h59);
    tick(1);
    check("carry_sec", sec24, 8'h00);
    check("carry_min", min24, 8'h01);
    check("carry_once", carry24_cnt, 1);

    run = 1'b0;
    tick(10);
    check("pause_sec", sec24, 8'h00);
    check("pause_min", min24, 8'h01);
    run = 1'b1;
    tick(1);
    check("resume_sec", sec24, 8'h01);
    check("resume_min", min24, 8'h01);

    @(negedge clk) tick_in = 1'b1;
    repeat (1000) @(negedge clk);
    tick_in = 1'b0;
    repeat (3) @(negedge clk);
    check("long_high_sec", sec24, 8'h02);

    press_hour(11);
    press_min(58);
    check("set_clears_sec", sec24, 8'h00);
    tick(59);
    check("pre12_hour", hour12, 8'h11);
    check("pre12_min", min12, 8'h59);
    check("pre12_sec", sec12, 8'h59);
    c0 = carry24_cnt;
    tick(1);
    check("wrap12_hour", hour12, 8'h00);
    check("wrap12_min", min12, 8'h00);
    check("wrap12_sec", sec12, 8'h00);
    check("wrap12_pulse", wrap12_cnt, 1);
    check("wrap12_with_carry", both12_cnt, 1);
    check("h24_noon_hour", hour24, 8'h12);
    check("h24_noon_nowrap", wrap24_cnt, 0);
    check("h24_noon_carry", carry24_cnt, c0 + 1);

    press_hour(11);
    press_min(59);
    tick(59);
    check("pre24_hour", hour24, 8'h23);
    check("pre24_min", min24, 8'h59);
    check("pre24_sec", sec24, 8'h59);
    tick(1);
    check("wrap24_hour", hour24, 8'h00);
    check("wrap24_min", min24, 8'h00);
    check("wrap24_sec", sec24, 8'h00);
    check("wrap24_pulse", wrap24_cnt, 1);
    check("wrap24_with_carry", both24_cnt, 1);
    check("wrap12_second", wrap12_cnt, 2);

    press_min(59);
    tick(30);
    check("pre_coin_min", min24, 8'h59);
    check("pre_coin_sec", sec24, 8'h30);
    c0 = carry24_cnt;
    @(negedge clk) tick_in = 1'b1;
    repeat (2) @(negedge clk);
    inc_min = 1'b1;
    @(negedge clk);
    inc_min = 1'b0;
    tick_in = 1'b0;
    repeat (3) @(negedge clk);
    check("coin_sec", sec24, 8'h00);
    check("coin_min", min24, 8'h00);
    check("coin_hour", hour24, 8'h00);
    check("coin_no_carry", carry24_cnt, c0);

    press_hour(23);
    check("hour23", hour24, 8'h23);
    check("hour23_h12", hour12, 8'h11);
    press_hour(1);
    check("hour_set_wrap24", hour24, 8'h00);
    check("hour_set_wrap12", hour12, 8'h00);
    check("hour_set_no_daywrap", wrap24_cnt, 1);

    tick(4);
    @(negedge clk) begin
      inc_min = 1'b1;
      inc_hour = 1'b1;
    end
    @(negedge clk) begin
      inc_min = 1'b0;
      inc_hour = 1'b0;
    end
    check("both_set_min", min24, 8'h01);
    check("both_set_hour", hour24, 8'h01);
    check("both_set_sec", sec24, 8'h00);

    tick(3);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midreset_sec", sec24, 8'h00);
    check("midreset_min", min24, 8'h00);
    check("midreset_hour", hour24, 8'h00);
    check("midreset_carry", carry24, 1'b0);
    @(negedge clk) rst_n = 1'b1;

`ifdef ALARM_CMP_EN
    al_hour = 8'h07;
    al_min  = 8'h30;
    press_hour(7);
    press_min(29);
    tick(58);
    al_arm = 1'b1;
    check("alarm_idle", alarm24, 1'b0);
    tick(1);
    check("alarm_before", alarm24, 1'b0);
    tick(1);
    check("alarm_time_min", min24, 8'h30);
    check("alarm_set24", alarm24, 1'b1);
    check("alarm_set12", alarm12, 1'b1);
    @(negedge clk) al_arm = 1'b0;
    @(negedge clk);
    check("alarm_disarm", alarm24, 1'b0);
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/tick_clock_counter.md
Name: tick_clock_counter

Overview:
- Consumer end of the selectable timer-tick divider: samples the divided `clk_timer` square wave in the 50 MHz domain.
- Converts each rising edge into a one-cycle event and advances a BCD time-of-day counter (hh:mm:ss).
- Supports pause and manual minute/hour setting; feeds the 7-segment display driver and any downstream carry consumers.

Parameters:
- HOUR_MOD, 24, hour modulus; legal values 12 or 24; hours count 0..HOUR_MOD-1.
- SYNC_STAGES, 2, synchroniser flops on tick_in; legal values 2 or 3.

Ports:
- clk  input  1  50 MHz system clock.
- rst_n  input  1  asynchronous active-low reset.
- tick_in  input  1  divided timer square wave; each rising edge = one count step.
- run  input  1  1 = count ticks; 0 = ignore ticks (pause).
- inc_min  input  1  debounced level, synchronous to clk; each rising edge = minute +1.
- inc_hour  input  1  debounced level, synchronous to clk; each rising edge = hour +1.
- sec_bcd  output  8  seconds, [7:4] tens, [3:0] units.
- min_bcd  output  8  minutes, same BCD format.
- hour_bcd  output  8  hours, same BCD format.
- sec_carry  output  1  one-cycle pulse on seconds 59->00.
- day_wrap  output  1  one-cycle pulse on (HOUR_MOD-1):59:59 -> 00:00:00.

Behaviour:
- One clock `clk`; asynchronous active-low reset `rst_n`.
- Reset values (all async-cleared): sec_bcd, min_bcd and hour_bcd = 8'h00; sec_carry = 0; day_wrap = 0; synchroniser and edge-detect flops = 0.
- Tick path:
  - tick_in passes through SYNC_STAGES flops, then one edge-detect flop.
  - tick_evt = synced & ~delayed.
  - With SYNC_STAGES=2, sec_bcd changes on the 3rd clk rising edge after tick_in rises (setup met).
  - A tick_in high pulse of any length produces exactly one tick_evt.
- Set path: inc_min and inc_hour each edge-detected with one register; no synchroniser.
- run=0: tick_evt discarded. Set events remain active. Synchroniser keeps running, so no spurious tick occurs when run returns to 1.
- Counting on accepted tick_evt:
  - Seconds units 9->0 carries into tens; tens 5 with units 9 -> 00 and asserts sec_carry for that cycle.
  - sec_carry increments minutes with the same 59->00 rule.
  - Minute wrap increments hours. Hour wraps HOUR_MOD-1 -> 00.
  - day_wrap is asserted in the same cycle as the hour wrap caused by the tick.
- Set events:
  - inc_min: minutes +1 with 59->00 wrap, no carry into hours; seconds cleared to 00.
  - inc_hour: hours +1 with wrap, no carry; minutes and seconds unchanged.
  - sec_carry and day_wrap are never asserted by set events.
- Simultaneous events in one cycle:
  - Any set event present: tick_evt that cycle is discarded.
  - inc_min and inc_hour both present: both applied (minute+1 with seconds cleared, hour+1).
- BCD digits only ever hold legal values, since state changes only by increment or reset.
- Reset mid-count: all state returns to reset values immediately, with no pulse emitted.
- All outputs are registered.

Optional Feature:
- Macro ALARM_CMP_EN.
- When defined, adds these ports:
  - alarm_hour_bcd  input  8
  - alarm_min_bcd  input  8
  - alarm_arm  input  1
  - alarm  output  1, reset value 0
- alarm set rule: registered high the cycle after hour_bcd==alarm_hour_bcd, min_bcd==alarm_min_bcd and sec_bcd==8'h00 are reached, while alarm_arm=1.
- alarm clear rule: low when alarm_arm=0 or min_bcd changes; clear has priority over set.
- Undefined: no alarm ports or logic; the port list is exactly as above.

Test Plan:
- Reset then release, 5 tick_in rising edges (run=1) -> sec_bcd 8'h05; min and hour 00; sec_carry never high.
- Preset 00:00:59 via ticks, one more tick -> sec_bcd 00, min_bcd 01, sec_carry high exactly 1 cycle.
- Set 23:59:59 (HOUR_MOD=24), tick -> 00:00:00, day_wrap and sec_carry high same single cycle; repeat with HOUR_MOD=12 from 11:59:59.
- run=0, 10 ticks -> time unchanged; run=1, 1 tick -> sec +1 only; also check tick_in held high 1000 cycles -> exactly one increment.
- At 00:59:30, inc_min rising edge coincident with tick_evt -> 00:00:00 (minute wraps, no hour carry, seconds cleared, tick dropped); inc_hour at hour 23 -> 00.
- ALARM_CMP_EN: alarm 07:30, arm=1, count from 07:29:58 -> alarm high after 07:30:00; drop arm -> low next cycle; undefined build -> no alarm ports.
